// File: rtl/sine_phase_ctrl.sv
// sine_phase_ctrl: phase-accumulator address generator for a sine ROM,
// controlled by a byte-wide command stream (S = stop, G = go, F + 3 bytes = new FTW).
module sine_phase_ctrl #(
    parameter int               ADDR_W  = 10,
    parameter int               ACC_W   = 24,
    parameter int               DIV     = 4,
    parameter logic [ACC_W-1:0] FTW_RST = ACC_W'(24'h004000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              sample_valid,
    output logic              running,
    output logic [ACC_W-1:0]  ftw,
    output logic              cfg_done
);

    // Tick -> address register -> ROM data register: two stages until a fresh sample.
    localparam int STAGES = 2;
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    localparam logic [7:0] CMD_STOP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
    localparam logic [7:0] CMD_FTW  = 8'h46;  // 'F'

    typedef enum logic [1:0] {
        IDLE,
        LD2,
        LD1,
        LD0
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [ACC_W-1:0]   acc;
    logic [15:0]        shadow;
    logic [23:0]        word;
    logic [ACC_W-1:0]   ftw_new;
    logic               run_nxt;
    logic               hi_ld;
    logic               lo_ld;
    logic               commit;
    logic               tick_run;
    logic [STAGES:1]    vld_pipe;

    // Free-running sample-rate divider; tick on the last count of each period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == CNT_MAX)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == CNT_MAX);

    // Command FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Command decode: run/stop in IDLE, three raw data bytes after 'F'.
    always_comb begin
        state_nxt = state;
        run_nxt   = running;
        hi_ld     = 1'b0;
        lo_ld     = 1'b0;
        commit    = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    case (rx_data)
                        CMD_STOP: run_nxt   = 1'b0;
                        CMD_GO:   run_nxt   = 1'b1;
                        CMD_FTW:  state_nxt = LD2;
                        default:  state_nxt = IDLE;
                    endcase
                end
                LD2: begin
                    hi_ld     = 1'b1;
                    state_nxt = LD1;
                end
                LD1: begin
                    lo_ld     = 1'b1;
                    state_nxt = LD0;
                end
                LD0: begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Last byte completes the 24-bit word; the cast fits it to the accumulator width.
    assign word    = {shadow, rx_data};
    assign ftw_new = ACC_W'(word);

    // Control registers: run flag, shadow bytes, active FTW and commit pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running  <= 1'b1;
            shadow   <= '0;
            ftw      <= FTW_RST;
            cfg_done <= 1'b0;
        end else begin
            running  <= run_nxt;
            cfg_done <= commit;
            if (hi_ld)
                shadow[15:8] <= rx_data;
            if (lo_ld)
                shadow[7:0] <= rx_data;
            if (commit)
                ftw <= ftw_new;
        end
    end

    // Phase accumulator: forced to zero (midscale entry) whenever the generator
    // is or is about to be stopped; otherwise steps by the current ftw on a tick.
    // A commit on the same edge only affects later ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (!run_nxt)
            acc <= '0;
        else if (tick && running)
            acc <= acc + ftw;
    end

    assign rom_addr = acc[ACC_W-1 -: ADDR_W];

    // Sample-valid delay line; flushed together with the accumulator on stop
    // so that no stale pulse escapes after running drops.
    assign tick_run = tick & running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe <= '0;
        else if (!run_nxt)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:1], tick_run};
    end

    assign sample_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_sine_phase_ctrl.sv
// Directed bench for sine_phase_ctrl: DIV=4 instance for the main scenarios,
// DIV=1 instance for commit-on-tick and zero-FTW behaviour.
module tb_sine_phase_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data,  rx_data1;
    logic        rx_valid, rx_valid1;
    logic [9:0]  rom_addr, rom_addr1;
    logic        sample_valid, sample_valid1;
    logic        running, running1;
    logic [23:0] ftw, ftw1;
    logic        cfg_done, cfg_done1;

    int n_tests = 0;
    int n_fail  = 0;

    sine_phase_ctrl #(.ADDR_W(10), .ACC_W(24), .DIV(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rom_addr(rom_addr), .sample_valid(sample_valid), .running(running),
        .ftw(ftw), .cfg_done(cfg_done)
    );

    sine_phase_ctrl #(.ADDR_W(10), .ACC_W(24), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rom_addr(rom_addr1), .sample_valid(sample_valid1), .running(running1),
        .ftw(ftw1), .cfg_done(cfg_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one cycle; returns just after the edge that consumed it.
    task automatic send(input bit which, input logic [7:0] b);
        if (which) begin rx_data1 = b; rx_valid1 = 1'b1; end
        else       begin rx_data  = b; rx_valid  = 1'b1; end
        step();
        rx_valid  = 1'b0;
        rx_valid1 = 1'b0;
    endtask

    // Advance to the next sample_valid pulse of the DIV=4 instance, bounded.
    task automatic wait_sv(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_valid && n < 16);
        chk(tag, 32'(sample_valid), 32'd1);
    endtask

    initial begin
        int a0, r0, nsv;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_data1 = '0; rx_valid1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_addr",  32'(rom_addr), 32'd0);
        chk("rst_ftw",   32'(ftw), 32'h004000);
        chk("rst_run",   32'(running), 32'd1);
        chk("rst_sv",    32'(sample_valid), 32'd0);
        chk("rst_cfg",   32'(cfg_done), 32'd0);
        rst = 1'b0;

        // Test 1: tick in cycles 3,7,11; address +1 per tick; pulse two cycles later
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("t1_addr_c%0d", c), 32'(rom_addr), 32'(c / 4));
            chk($sformatf("t1_sv_c%0d", c), 32'(sample_valid),
                32'((c >= 5 && c % 4 == 1) ? 1 : 0));
            step();
        end

        // Test 2: load FTW 0x008000, +2 per tick, wraps after 512 ticks
        send(0, 8'h46); send(0, 8'h00); send(0, 8'h80); send(0, 8'h00);
        chk("t2_cfg",  32'(cfg_done), 32'd1);
        chk("t2_ftw",  32'(ftw), 32'h008000);
        step();
        chk("t2_cfg_1cyc", 32'(cfg_done), 32'd0);
        wait_sv("t2_sv0");
        a0 = int'(rom_addr);
        wait_sv("t2_sv1");
        chk("t2_step2", 32'(rom_addr), 32'((a0 + 2) % 1024));
        for (int i = 1; i < 256; i++) wait_sv("t2_sv_loop");
        chk("t2_half", 32'(rom_addr), 32'((a0 + 512) % 1024));
        for (int i = 0; i < 256; i++) wait_sv("t2_sv_loop");
        chk("t2_wrap", 32'(rom_addr), 32'(a0));

        // Test 4: reset mid-load discards partial word, FSM back in IDLE
        send(0, 8'h46); send(0, 8'h12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_ftw", 32'(ftw), 32'h004000);
        chk("t4_run", 32'(running), 32'd1);

        // Test 3: stop, mute, restart ('S' here also proves the FSM is IDLE)
        send(0, 8'h53);
        chk("t3_run",  32'(running), 32'd0);
        chk("t3_addr", 32'(rom_addr), 32'd0);
        nsv = 0;
        for (int i = 0; i < 20; i++) begin
            if (sample_valid) nsv++;
            if (rom_addr != 10'd0) nsv += 100;
            step();
        end
        chk("t3_quiet", 32'(nsv), 32'd0);
        send(0, 8'h53);
        chk("t3_s_noop", 32'(running), 32'd0);
        send(0, 8'h47);
        chk("t3_go", 32'(running), 32'd1);
        wait_sv("t3_sv");
        chk("t3_addr1", 32'(rom_addr), 32'd1);
        chk("t3_ftw_keep", 32'(ftw), 32'h004000);

        // Test 5: command letters inside the load are plain data
        send(0, 8'h46); send(0, 8'h47); send(0, 8'h53); send(0, 8'h46);
        chk("t5_ftw", 32'(ftw), 32'h475346);
        chk("t5_cfg", 32'(cfg_done), 32'd1);
        chk("t5_run", 32'(running), 32'd1);
        send(0, 8'h99);
        chk("t5_stray_ftw", 32'(ftw), 32'h475346);
        chk("t5_stray_run", 32'(running), 32'd1);
        send(0, 8'h47);
        chk("t5_g_noop", 32'(running), 32'd1);
        send(0, 8'h53);
        chk("t5_stop_after_stray", 32'(running), 32'd0);

        // Test 6 (DIV=1): commit on a tick -> old step (+1) then new step (+4)
        send(1, 8'h46); send(1, 8'h01); send(1, 8'h00);
        rx_data1 = 8'h00; rx_valid1 = 1'b1;
        r0 = int'(rom_addr1);
        step();
        rx_valid1 = 1'b0;
        chk("t6_ftw",   32'(ftw1), 32'h010000);
        chk("t6_cfg",   32'(cfg_done1), 32'd1);
        chk("t6_old",   32'(rom_addr1), 32'((r0 + 1) % 1024));
        step();
        chk("t6_new",   32'(rom_addr1), 32'((r0 + 5) % 1024));

        // FTW=0: address freezes, sample_valid keeps pulsing every tick
        send(1, 8'h46); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
        chk("t6_ftw0", 32'(ftw1), 32'h000000);
        r0 = int'(rom_addr1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_freeze", 32'(rom_addr1), 32'(r0));
            chk("t6_sv0",    32'(sample_valid1), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
